// File: rtl/shared_mem_pkg.sv
// Shared definitions for the PS/PL shared memory and the matrix calculator:
// command encodings, FSM states, the word address map and the write-port request.
package shared_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_IDLE  = 3'd4;

  localparam logic [ADDR_W-1:0] OPERAND_ADDR = 8'd255;
  localparam logic [ADDR_W-1:0] INSTR_FIRST  = 8'd1;
  localparam logic [ADDR_W-1:0] INSTR_LAST   = 8'd5;
  localparam logic [ADDR_W-1:0] RESULT_FIRST = 8'd6;
  localparam logic [ADDR_W-1:0] RESULT_LAST  = 8'd10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/mem_array_256x32.sv
// Dual-write, dual-read word array. Port A wins a same-address write collision;
// both read ports are registered and return the pre-write word.
module mem_array_256x32
  import shared_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  wr_req_t           wr_a,
  input  wr_req_t           wr_b,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
  logic [DATA_W-1:0] rdata_b_d, rdata_b_q;
  logic              wr_b_en;

  assign wr_b_en = wr_b.we && !(wr_a.we && (wr_a.addr == wr_b.addr));

  always_ff @(posedge clk) begin
    if (wr_a.we) mem[wr_a.addr] <= wr_a.data;
    if (wr_b_en) mem[wr_b.addr] <= wr_b.data;
  end

  // Reads sample the array before this edge's writes land, giving read-first.
  always_comb begin
    rdata_a_d = rdata_a_q;
    if (re_a) rdata_a_d = mem[raddr_a];
    rdata_b_d = mem[raddr_b];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/shared_mem.sv
// Shared memory, PL command responder and ready/done handshake FSM.
// Define SHARED_MEM_CLEAR_EN to zero the whole array after every reset.
module shared_mem
  import shared_mem_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int OPERAND_ADDR = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] address_pl,
  input  logic [DATA_W-1:0] data_pl,
  output logic [DATA_W-1:0] data_in,
  input  logic              done_pl,
  output logic              ready,
  input  logic              ps_we,
  input  logic [ADDR_W-1:0] ps_addr,
  input  logic [DATA_W-1:0] ps_wdata,
  output logic [DATA_W-1:0] ps_rdata,
  input  logic              ps_start,
  input  logic              ps_ack,
  output logic              busy,
  output logic              done_irq,
  output logic              err
);

  if (DEPTH > 256 || OPERAND_ADDR >= DEPTH) begin : g_bad_cfg
    $error("shared_mem: DEPTH/OPERAND_ADDR out of range for 8-bit addressing");
  end

  state_e  state_d, state_q;
  logic    ready_d, ready_q;
  logic    busy_d, busy_q;
  logic    done_irq_d, done_irq_q;
  logic    err_d, err_q;
  wr_req_t wr_pl, wr_ps;
  logic    re_pl, ps_open, err_set;

`ifdef SHARED_MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
`endif

  // Memory port steering; the clear sweep borrows the PL write port.
  always_comb begin
    ps_open = (state_q == ST_IDLE) || (state_q == ST_DONE);
    wr_pl   = '{we: (cmd == CMD_WRITE) && (state_q != ST_CLEAR), addr: address_pl, data: data_pl};
`ifdef SHARED_MEM_CLEAR_EN
    if (state_q == ST_CLEAR) wr_pl = '{we: 1'b1, addr: clr_cnt_q, data: '0};
`endif
    wr_ps   = '{we: ps_we && ps_open, addr: ps_addr, data: ps_wdata};
    re_pl   = (cmd == CMD_READ) && (state_q != ST_CLEAR);
    err_set = ps_we && ((state_q == ST_RUN) ||
                        (ps_open && wr_pl.we && (address_pl == ps_addr)));
  end

  mem_array_256x32 #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_a    (wr_pl),
    .wr_b    (wr_ps),
    .re_a    (re_pl),
    .raddr_a (address_pl),
    .rdata_a (data_in),
    .raddr_b (ps_addr),
    .rdata_b (ps_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef SHARED_MEM_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
    end else begin
      state_q   <= state_d;
`ifdef SHARED_MEM_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef SHARED_MEM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef SHARED_MEM_CLEAR_EN
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: if (ps_start) state_d = ST_RUN;
      ST_RUN:  if (done_pl)  state_d = ST_DONE;
      ST_DONE: if (ps_ack)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they move with it.
  always_comb begin
    ready_d    = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    done_irq_d = (state_q == ST_RUN) && done_pl;
    err_d      = err_q | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_irq_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_irq_q <= done_irq_d;
      err_q      <= err_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done_irq = done_irq_q;
  assign err      = err_q;

endmodule

// File: tb/tb_shared_mem.sv
// Directed bench for shared_mem: port reads/writes, collisions, handshake, reset.
module tb_shared_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd;
  logic [7:0]  address_pl;
  logic [31:0] data_pl;
  logic [31:0] data_in;
  logic        done_pl;
  logic        ready;
  logic        ps_we;
  logic [7:0]  ps_addr;
  logic [31:0] ps_wdata;
  logic [31:0] ps_rdata;
  logic        ps_start;
  logic        ps_ack;
  logic        busy;
  logic        done_irq;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

`ifdef SHARED_MEM_CLEAR_EN
  localparam logic [31:0] EXP_200 = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_200 = 32'hFFFF_FFFF;
`endif

  shared_mem dut (
    .clk(clk), .rst(rst), .cmd(cmd), .address_pl(address_pl), .data_pl(data_pl),
    .data_in(data_in), .done_pl(done_pl), .ready(ready), .ps_we(ps_we),
    .ps_addr(ps_addr), .ps_wdata(ps_wdata), .ps_rdata(ps_rdata),
    .ps_start(ps_start), .ps_ack(ps_ack), .busy(busy), .done_irq(done_irq), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the post-reset clear sweep; a no-op without it.
  task automatic wait_clear();
`ifdef SHARED_MEM_CLEAR_EN
    int n = 0;
    while (!busy && n < 8) begin tick(); n++; end
    while (busy && n < 400) begin tick(); n++; end
    chk("clear_timeout", {31'b0, busy}, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b0; cmd = 3'd4; address_pl = '0; data_pl = '0; done_pl = 1'b0;
    ps_we = 1'b0; ps_addr = '0; ps_wdata = '0; ps_start = 1'b0; ps_ack = 1'b0;
    tick(); tick();
    chk("rst_data_in",  data_in, 32'h0);
    chk("rst_ps_rdata", ps_rdata, 32'h0);
    chk("rst_ready",    {31'b0, ready}, 32'h0);
    chk("rst_busy",     {31'b0, busy}, 32'h0);
    chk("rst_done_irq", {31'b0, done_irq}, 32'h0);
    chk("rst_err",      {31'b0, err}, 32'h0);
    rst = 1'b1;
    wait_clear();

    // PS write, PL and PS readback of the operand word
    ps_we = 1'b1; ps_addr = 8'd255; ps_wdata = 32'h1234_5678; tick();
    ps_we = 1'b0; cmd = 3'd3; address_pl = 8'd255; tick();
    chk("pl_read_255", data_in, 32'h1234_5678);
    chk("ps_read_255", ps_rdata, 32'h1234_5678);
    cmd = 3'd4; address_pl = 8'd0; tick();
    chk("data_in_hold", data_in, 32'h1234_5678);

    // Simultaneous writes, different addresses
    ps_we = 1'b1; ps_addr = 8'd8; ps_wdata = 32'h1111_1111;
    cmd = 3'd2; address_pl = 8'd9; data_pl = 32'h2222_2222; tick();
    ps_we = 1'b0; cmd = 3'd3; address_pl = 8'd9; ps_addr = 8'd8; tick();
    chk("dual_wr_pl", data_in, 32'h2222_2222);
    chk("dual_wr_ps", ps_rdata, 32'h1111_1111);
    chk("dual_wr_err", {31'b0, err}, 32'h0);

    // Write then read on consecutive cycles, then read-first collisions
    cmd = 3'd2; address_pl = 8'd6; data_pl = 32'h5; tick();
    cmd = 3'd3; tick();
    chk("wr_then_rd_6", data_in, 32'h5);
    cmd = 3'd2; data_pl = 32'h66; ps_addr = 8'd6; tick();
    chk("rdw_ps_old", ps_rdata, 32'h5);
    cmd = 3'd3; ps_we = 1'b1; ps_wdata = 32'h77; tick();
    chk("rdw_pl_old", data_in, 32'h66);
    ps_we = 1'b0; tick();
    chk("rdw_pl_new", data_in, 32'h77);
    cmd = 3'd4;

    // Handshake with a dropped PS write during RUN
    ps_we = 1'b1; ps_addr = 8'd3; ps_wdata = 32'h3333_3333; tick();
    ps_we = 1'b0; ps_start = 1'b1; tick();
    ps_start = 1'b0;
    chk("start_ready", {31'b0, ready}, 32'h1);
    chk("start_busy",  {31'b0, busy}, 32'h1);
    chk("start_irq",   {31'b0, done_irq}, 32'h0);
    ps_we = 1'b1; ps_wdata = 32'hDEAD_BEEF; tick();
    ps_we = 1'b0;
    chk("run_wr_err", {31'b0, err}, 32'h1);
    ps_start = 1'b1; tick();
    ps_start = 1'b0;
    chk("run_start_ignored", {31'b0, ready}, 32'h1);
    repeat (17) tick();
    done_pl = 1'b1; tick();
    done_pl = 1'b0;
    chk("done_ready", {31'b0, ready}, 32'h0);
    chk("done_irq",   {31'b0, done_irq}, 32'h1);
    chk("done_busy",  {31'b0, busy}, 32'h1);
    ps_start = 1'b1; tick();
    ps_start = 1'b0;
    chk("irq_one_cycle",      {31'b0, done_irq}, 32'h0);
    chk("done_start_ignored", {31'b0, ready}, 32'h0);
    ps_ack = 1'b1; tick();
    ps_ack = 1'b0;
    chk("ack_busy", {31'b0, busy}, 32'h0);
    chk("run_wr_dropped", ps_rdata, 32'h3333_3333);

    // err is cleared only by reset
    rst = 1'b0; tick();
    chk("err_reset", {31'b0, err}, 32'h0);
    rst = 1'b1;
    wait_clear();

    ps_we = 1'b1; ps_addr = 8'd3; ps_wdata = 32'hDEAD_BEEF; tick();
    ps_we = 1'b0; tick();
    chk("idle_wr_stored", ps_rdata, 32'hDEAD_BEEF);

    // Same-address collision: PL wins, err set
    ps_we = 1'b1; ps_addr = 8'd7; ps_wdata = 32'hAAAA_0000;
    cmd = 3'd2; address_pl = 8'd7; data_pl = 32'h0000_BBBB; tick();
    ps_we = 1'b0; cmd = 3'd3; tick();
    chk("coll_pl", data_in, 32'h0000_BBBB);
    chk("coll_ps", ps_rdata, 32'h0000_BBBB);
    chk("coll_err", {31'b0, err}, 32'h1);
    cmd = 3'd4;

    // Memory across reset: retained, or zeroed by the clear sweep
    ps_we = 1'b1; ps_addr = 8'd200; ps_wdata = 32'hFFFF_FFFF; tick();
    ps_we = 1'b0; rst = 1'b0; tick();
    rst = 1'b1;
    wait_clear();
    cmd = 3'd3; address_pl = 8'd200; tick();
    chk("post_rst_pl_200", data_in, EXP_200);
    chk("post_rst_ps_200", ps_rdata, EXP_200);
    cmd = 3'd4;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_mem.md
# shared_mem

Single-clock 256×32 shared memory and command responder between the PS register interface and the PL matrix calculator. It services the calculator's memory command bus: read, write or idle on `cmd`, with `address_pl`, `data_pl` and `data_in`. It also gives the PS a write/readback port, and generates the `ready`/`done` handshake that starts the calculator and reports completion.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; address width is fixed at 8.
- OPERAND_ADDR, 255: word holding the packed 4-bit operands.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- cmd  in  3  PL command: 2=write, 3=read, 4=idle; 0/1/5/6/7 are treated as idle
- address_pl  in  8  PL word address
- data_pl  in  32  PL write data
- data_in  out  32  PL read data (calculator's `data_in`)
- done_pl  in  1  calculator completion level
- ready  out  1  start level to the calculator
- ps_we  in  1  PS write strobe
- ps_addr  in  8  PS address, used for both write and readback
- ps_wdata  in  32  PS write data
- ps_rdata  out  32  PS readback data
- ps_start  in  1  PS start pulse
- ps_ack  in  1  PS acknowledge of completion
- busy  out  1  high from ps_start accept until ps_ack
- done_irq  out  1  one-cycle completion pulse
- err  out  1  sticky; set when a PS write is dropped

## Operation
- **FSM states:** CLEAR (macro only), IDLE, RUN, DONE.
- **IDLE:**
  - PS writes are accepted.
  - `ps_start`=1 → RUN, with `ready`=1 and `busy`=1 on the next cycle.
- **RUN:**
  - `ready` is held at 1.
  - PS writes are dropped and set `err`.
  - `done_pl`=1 → DONE. On the next cycle `ready`=0 and `done_irq`=1 for exactly one cycle.
- **DONE:**
  - PS writes are accepted.
  - `ps_ack`=1 → IDLE, with `busy`=0 on the next cycle.
  - `ps_start` is ignored in DONE; so is `ps_start` arriving in RUN.
- **PL write (cmd=2):** mem[address_pl] ← data_pl at the clock edge. Accepted in any state.
- **PL read (cmd=3):** `data_in` ← mem[address_pl], registered. While cmd≠3, `data_in` holds its last value.
- **PS readback:** every cycle, `ps_rdata` ← mem[ps_addr], registered.
- **Simultaneous write, same address:** the PL write wins, the PS write is dropped and `err` is set.
- **Simultaneous write, different addresses:** both writes complete.
- **Read-during-write, same address (either port):** returns the old word (read-first).
- **`err` clearing:** cleared only by reset.
- **Reset values:** `data_in`=0, `ps_rdata`=0, `ready`=0, `busy`=0, `done_irq`=0, `err`=0. The state goes to IDLE, or to CLEAR with the macro.
- **Reset mid-operation:** the reset state takes effect on the next edge. Without the macro, memory contents are retained.

## Timing
- PL read latency: 1 cycle. `address_pl`/`cmd` sampled at edge N give `data_in` valid after edge N.
- PS readback latency: 1 cycle.
- Writes become visible to a read issued on the following cycle.
- `ps_start` to `ready`: 1 cycle.
- `done_pl` to `done_irq`: 1 cycle.
- `ready` falls on the same edge that `done_irq` rises.
- There is no backpressure. Every command is serviced in the cycle it is sampled.

## Configuration
- **Macro:** `SHARED_MEM_CLEAR_EN`.
- **With the macro defined:**
  - Reset enters CLEAR. An 8-bit counter writes 0 to addresses 0..255, one word per cycle.
  - This takes 256 cycles, after which the FSM moves to IDLE.
  - During CLEAR, `busy`=1 and `ready`=0. PS writes are dropped without setting `err`; PL commands are ignored and `data_in` holds 0.
  - Reset asserted during CLEAR restarts the counter at 0.
- **Without the macro:** there is no CLEAR state, reset goes straight to IDLE, and memory is uninitialised until written.

## Structure
- **Package `shared_mem_pkg`:**
  - Command encodings: CMD_WRITE=2, CMD_READ=3, CMD_IDLE=4.
  - FSM state enum.
  - Address map: OPERAND_ADDR=255, instruction words 1..5, result words 6..10.
  - The same package is imported by the calculator.
- **Sub-module `mem_array_256x32`:**
  - Two write ports with a fixed PL-priority mux on address collision.
  - Two registered read-first read ports.
- **Top level:** FSM, handshake logic, error flag and clear counter.

## Test plan
- PS writes 0x12345678 to address 255, then PL cmd=3 at address 255 → `data_in`=0x12345678 one cycle later; `ps_rdata` at ps_addr=255 matches.
- Same cycle, PS writes 0xAAAA0000 and PL cmd=2 writes 0x0000BBBB, both to address 7 → next read of 7 returns 0x0000BBBB and `err`=1.
- `ps_start` pulse → `ready`=1 next cycle. `done_pl` raised 20 cycles later → `ready`=0 and a single-cycle `done_irq`=1. `ps_ack` → `busy`=0.
- PS write to address 3 during RUN → address 3 unchanged and `err`=1. The same write in IDLE → stored.
- PL write 0x5 then read of address 6 on consecutive cycles → 0x5. Read and write of address 6 in the same cycle → old value.
- With `SHARED_MEM_CLEAR_EN`: write 0xFFFFFFFF to address 200, assert reset, wait 256 cycles → `busy` falls and address 200 reads 0. Without the macro, address 200 reads 0xFFFFFFFF.
